// File: rtl/if_id_register.sv
// IF/ID pipeline register: 2-entry skid buffer between fetch and decode with a
// valid/ready handshake, branch flush, and pre-split instruction fields.
module if_id_register #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC_In,
  input  logic [INST_W-1:0] Instruction,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] PC_Out,
  output logic [INST_W-1:0] Instruction_Out,
  output logic [6:0]        opcode,
  output logic [4:0]        rd,
  output logic [2:0]        funct3,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [6:0]        funct7
);

  // StEmpty: main invalid; StFull: main valid; StSkid: main and skid valid.
  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic              in_ready_q, in_ready_d;

  logic accept;
  logic consume;

  assign out_valid       = (state_q != StEmpty);
  assign in_ready        = in_ready_q;
  assign PC_Out          = main_pc_q;
  assign Instruction_Out = main_inst_q;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid & out_ready;

  // Fields are plain slices so decode sees them in the same cycle as the word.
  assign opcode = Instruction_Out[6:0];
  assign rd     = Instruction_Out[11:7];
  assign funct3 = Instruction_Out[14:12];
  assign rs1    = Instruction_Out[19:15];
  assign rs2    = Instruction_Out[24:20];
  assign funct7 = Instruction_Out[31:25];

  // Next-state and entry updates; flush overrides any handshake this cycle.
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    if (flush) begin
      state_d     = StEmpty;
      main_pc_d   = '0;
      main_inst_d = NOP_INST;
      skid_pc_d   = '0;
      skid_inst_d = NOP_INST;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StFull;
            main_pc_d   = PC_In;
            main_inst_d = Instruction;
          end
        end
        StFull: begin
          if (accept && consume) begin
            main_pc_d   = PC_In;
            main_inst_d = Instruction;
          end else if (accept) begin
            // Decode stalled: park the new word behind the head.
            state_d     = StSkid;
            skid_pc_d   = PC_In;
            skid_inst_d = Instruction;
          end else if (consume) begin
            // Main keeps the consumed word so the outputs stay stable.
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (consume) begin
            state_d     = StFull;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    // Registered ready: low only while the skid entry is occupied.
    in_ready_d = (state_d != StSkid);
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StEmpty;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_if_id_register.sv
// Testbench for if_id_register: directed scenarios plus random traffic, checked
// against a queue-based model of a 2-deep FIFO with held head outputs.
module tb_if_id_register;

  localparam logic [31:0] Nop = 32'h00000013;

  logic        clk;
  logic        reset;
  logic [63:0] PC_In;
  logic [31:0] Instruction;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] PC_Out;
  logic [31:0] Instruction_Out;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  if_id_register dut (
    .clk             (clk),
    .reset           (reset),
    .PC_In           (PC_In),
    .Instruction     (Instruction),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .flush           (flush),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .PC_Out          (PC_Out),
    .Instruction_Out (Instruction_Out),
    .opcode          (opcode),
    .rd              (rd),
    .funct3          (funct3),
    .rs1             (rs1),
    .rs2             (rs2),
    .funct7          (funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: FIFO of held words plus the word currently shown on the outputs.
  logic [63:0] model_pc[$];
  logic [31:0] model_inst[$];
  logic [63:0] disp_pc;
  logic [31:0] disp_inst;
  bit          model_known = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 64'(out_valid), 64'(model_pc.size() > 0));
    check("in_ready", 64'(in_ready), 64'(model_pc.size() < 2));
    check("PC_Out", PC_Out, disp_pc);
    check("Instruction_Out", 64'(Instruction_Out), 64'(disp_inst));
    check("opcode", 64'(opcode), 64'(disp_inst[6:0]));
    check("rd", 64'(rd), 64'(disp_inst[11:7]));
    check("funct3", 64'(funct3), 64'(disp_inst[14:12]));
    check("rs1", 64'(rs1), 64'(disp_inst[19:15]));
    check("rs2", 64'(rs2), 64'(disp_inst[24:20]));
    check("funct7", 64'(funct7), 64'(disp_inst[31:25]));
  endtask

  task automatic model_step(input logic rst, input logic iv, input logic [63:0] pc,
                            input logic [31:0] inst, input logic fl, input logic ordy);
    bit acc;
    bit cons;
    if (!rst || fl) begin
      model_pc.delete();
      model_inst.delete();
      disp_pc   = '0;
      disp_inst = Nop;
      if (!rst) model_known = 1'b1;
    end else begin
      acc  = iv && (model_pc.size() < 2);
      cons = ordy && (model_pc.size() > 0);
      if (cons) begin
        void'(model_pc.pop_front());
        void'(model_inst.pop_front());
      end
      if (acc) begin
        model_pc.push_back(pc);
        model_inst.push_back(inst);
      end
      if (model_pc.size() > 0) begin
        disp_pc   = model_pc[0];
        disp_inst = model_inst[0];
      end
    end
  endtask

  // Drive one cycle's inputs, compare the outputs settled from the previous
  // edge, then advance the model by the edge these inputs will see.
  task automatic cyc(input logic rst, input logic iv, input logic [63:0] pc,
                     input logic [31:0] inst, input logic fl, input logic ordy);
    @(negedge clk);
    reset       = rst;
    in_valid    = iv;
    PC_In       = pc;
    Instruction = inst;
    flush       = fl;
    out_ready   = ordy;
    #1;
    if (model_known) compare_all();
    model_step(rst, iv, pc, inst, fl, ordy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; PC_In = '0; Instruction = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Scenario 1: reset for two cycles.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_inst", 64'(Instruction_Out), 64'(Nop));
    check("rst_pc", PC_Out, 64'(0));
    check("rst_opcode", 64'(opcode), 64'(7'h13));

    // Scenario 2: streaming with decode always ready.
    cyc(1, 1, 0, 32'h00500093, 0, 1);
    cyc(1, 1, 4, 32'h00A00113, 0, 1);
    cyc(1, 1, 8, 32'h002081B3, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    check("s2_rd", 64'(rd), 64'(3));
    check("s2_rs1", 64'(rs1), 64'(1));
    check("s2_rs2", 64'(rs2), 64'(2));
    check("s2_opcode", 64'(opcode), 64'(7'h33));
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);

    // Scenario 3: decode stalled while two words arrive, then drained.
    cyc(1, 1, 0, 32'h11111113, 0, 0);
    cyc(1, 1, 4, 32'h22222213, 0, 0);
    cyc(1, 1, 8, 32'h33333313, 0, 0);
    check("s3_in_ready_low", 64'(in_ready), 64'(0));
    check("s3_head_pc", PC_Out, 64'(0));
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    check("s3_in_ready_back", 64'(in_ready), 64'(1));

    // Scenario 4: flush in SKID with a same-edge offered word.
    cyc(1, 1, 64'h100, 32'hAAAA0013, 0, 0);
    cyc(1, 1, 64'h104, 32'hBBBB0013, 0, 0);
    cyc(1, 1, 64'h108, 32'hCCCC0013, 1, 0);
    cyc(1, 0, 0, 0, 0, 1);
    check("s4_out_valid", 64'(out_valid), 64'(0));
    check("s4_in_ready", 64'(in_ready), 64'(1));
    check("s4_inst", 64'(Instruction_Out), 64'(Nop));
    cyc(1, 0, 0, 0, 0, 1);

    // Scenario 5: reset in SKID, then a fresh word.
    cyc(1, 1, 64'h200, 32'hDDDD0013, 0, 0);
    cyc(1, 1, 64'h204, 32'hEEEE0013, 0, 0);
    cyc(0, 1, 64'h208, 32'hFFFF0013, 1, 1);
    cyc(1, 1, 64'h300, 32'h12345013, 0, 1);
    check("s5_out_valid", 64'(out_valid), 64'(0));
    check("s5_pc", PC_Out, 64'(0));
    cyc(1, 0, 0, 0, 0, 0);
    check("s5_first_pc", PC_Out, 64'h300);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic        r_rst;
      logic        r_fl;
      logic [63:0] r_pc;
      r_rst = ($urandom_range(0, 99) >= 2);
      r_fl  = ($urandom_range(0, 99) < 5);
      r_pc  = {$urandom(), $urandom()} & ~64'h3;
      cyc(r_rst, 1'($urandom_range(0, 1)), r_pc, $urandom(), r_fl,
          1'($urandom_range(0, 2) != 0));
    end
    cyc(1, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
